hazard_forward_unit: RTL and testbench
======================================

HAZARD_FORWARD_UNIT -- requirements
Module: hazard_forward_unit

Interface
REQ-001 SHALL have one clock and an asynchronous active-low reset: clk input 1, rising-edge clock; rst_n input 1, asynchronous active-low reset.
REQ-002 SHALL have ports: id_rs input 5, rs of the instruction in ID; id_rt input 5, rt of the instruction in ID; id_use_rs input 1, ID instruction reads rs; id_use_rt input 1, ID instruction reads rt.
REQ-003 SHALL have ports: ex_dest input 5, EX-stage RegDst mux output; ex_regwrite input 1, EX instruction writes a register; ex_memread input 1, EX instruction is a load; ex_redirect input 1, EX branch taken or jump.
REQ-004 SHALL have outputs: ForwardA output 2 and ForwardB output 2, registered EX forward selects (00 regfile, 01 WB data, 10 EX/MEM ALU result, 11 never driven).
REQ-005 SHALL have outputs: pc_write output 1, PC enable; ifid_write output 1, IF/ID enable; ifid_flush output 1, IF/ID clear; idex_flush output 1, ID/EX bubble insert.
REQ-006 SHALL have output stall_cnt output 16, saturating count of stall cycles.

Function
REQ-007 SHALL keep shadow stage registers mem_{dest,regwrite} and wb_{dest,regwrite}, loaded from ex_* and mem_* respectively on every clock edge (never held).
REQ-008 A source hazard is a used source (id_use_x=1) whose register equals a producer dest where the producer regwrite=1 and dest!=0.
REQ-009 Next ForwardX SHALL be 10 if EX producer matches and ex_memread=0; else 01 if MEM shadow matches; else 00. The EX match takes priority over the MEM match.
REQ-010 A load-use condition (EX producer match with ex_memread=1) SHALL give pc_write=0, ifid_write=0, idex_flush=1 combinationally in the same cycle.
REQ-011 ex_redirect=1 SHALL give ifid_flush=1, idex_flush=1, pc_write=1, ifid_write=1, and SHALL override any stall in the same cycle.
REQ-012 Whenever idex_flush=1, the ForwardA and ForwardB registers SHALL load 00 at the next edge.
REQ-013 FSM states: RUN and STALL. RUN->STALL when a stall is asserted and ex_redirect=0. STALL->RUN when no stall condition holds. STALL->STALL while a stall condition persists. Redirect forces RUN.
REQ-014 stall_cnt SHALL increment by 1 on each edge where pc_write=0, and SHALL saturate at 16'hFFFF.
REQ-015 WB-stage writes SHALL NOT be forwarded. The register file writes in the first half-cycle and reads in the second, so a WB match yields 00.

Reset
REQ-016 rst_n=0 SHALL asynchronously set ForwardA=00, ForwardB=00, shadow regwrite bits=0, shadow dests=0, FSM=RUN, stall_cnt=0.
REQ-017 After reset: pc_write=1, ifid_write=1, ifid_flush=0, idex_flush=0, provided inputs present no hazard.
REQ-018 Reset asserted mid-stall SHALL abandon the stall, with no residual bubble after release.

Configuration
REQ-019 Macro HFU_FWD_EN SHALL control forwarding.
REQ-020 With HFU_FWD_EN defined, the unit SHALL behave as in REQ-009 and REQ-010.
REQ-021 Without HFU_FWD_EN, ForwardA and ForwardB SHALL be constant 00. Any EX or MEM producer match SHALL stall, as in REQ-010. A RAW hazard on the immediately preceding producer therefore costs 2 stall cycles.

Structure
REQ-022 A shared package SHALL hold: forward-select constants FWD_REG=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10; FSM state encodings; and the stall counter width of 16.
REQ-023 Sub-module hazard_compare SHALL implement one combinational source-versus-producer match, instanced once per source/producer pair.

Verification
REQ-024 Forward from EX: add $3 in EX (ex_regwrite=1, ex_dest=3), ID reads id_rs=3 -> ForwardA=10 one edge later, no stall.
REQ-025 Forward from MEM with priority: mem_dest=5 and ex_dest=5, both regwrite, ID id_rt=5 -> ForwardB=10. With only mem_dest=5 -> ForwardB=01.
REQ-026 Load-use: ex_memread=1, ex_dest=7, id_rs=7 -> pc_write=0 and idex_flush=1 for exactly 1 cycle, stall_cnt 0->1, next ForwardA=00, then 01 on the retried issue.
REQ-027 $zero and unused source: ex_dest=0 matching id_rs=0, or id_use_rt=0 with a matching rt -> ForwardX=00, no stall.
REQ-028 Redirect during load-use: ex_redirect=1 plus load-use -> ifid_flush=1, idex_flush=1, pc_write=1, stall_cnt unchanged.
REQ-029 Saturation and reset: stall_cnt preloaded to FFFF plus another stall -> stays FFFF. rst_n pulsed mid-stall -> all outputs reach reset values with no clock edge required.

Source files
------------

// File: rtl/hazard_forward_unit_pkg.sv
// Shared constants for the hazard/forwarding unit: forward selects, FSM encodings,
// counter width, producer record and the forward-select priority helper.
package hazard_forward_unit_pkg;

   localparam logic [1:0] FWD_REG = 2'b00;
   localparam logic [1:0] FWD_WB  = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;

   localparam logic [0:0] ST_RUN   = 1'b0;
   localparam logic [0:0] ST_STALL = 1'b1;

   localparam int STALL_CNT_W = 16;
   localparam int REG_W       = 5;

   typedef struct packed {
      logic [REG_W-1:0] dest;
      logic             regwrite;
   } prod_t;

   // EX result beats MEM; a WB producer is served by the regfile write-through.
   function automatic logic [1:0] fwd_sel(input logic ex_hit,
                                          input logic mem_hit,
                                          input logic wb_hit,
                                          input logic ex_load);
      logic [1:0] sel;
      sel = FWD_REG;
      if (ex_hit && !ex_load) begin
         sel = FWD_MEM;
      end else if (mem_hit) begin
         sel = FWD_WB;
      end else if (wb_hit) begin
         sel = FWD_REG;
      end
      return sel;
   endfunction

endpackage

// File: rtl/hazard_compare.sv
// One source-versus-producer RAW match; $zero and unused sources never match.
// Purely combinational, no backpressure.
module hazard_compare
   import hazard_forward_unit_pkg::*;
(
   input  logic [REG_W-1:0] src,
   input  logic             src_used,
   input  prod_t            prod,
   output logic             hit
);

   assign hit = src_used & prod.regwrite & (prod.dest != '0) & (src == prod.dest);

endmodule

// File: rtl/hazard_forward_unit.sv
// RAW hazard detection and EX forward-select generation; forwarding enabled by HFU_FWD_EN.
// Forward selects registered (1 edge); stall/flush controls combinational (0 cycles).
// Backpressure: load-use (or any EX/MEM match without forwarding) holds PC and IF/ID and bubbles ID/EX.
module hazard_forward_unit
   import hazard_forward_unit_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [REG_W-1:0]       id_rs,
   input  logic [REG_W-1:0]       id_rt,
   input  logic                   id_use_rs,
   input  logic                   id_use_rt,
   input  logic [REG_W-1:0]       ex_dest,
   input  logic                   ex_regwrite,
   input  logic                   ex_memread,
   input  logic                   ex_redirect,
   output logic [1:0]             ForwardA,
   output logic [1:0]             ForwardB,
   output logic                   pc_write,
   output logic                   ifid_write,
   output logic                   ifid_flush,
   output logic                   idex_flush,
   output logic [STALL_CNT_W-1:0] stall_cnt
);

   prod_t ex_prod;
   prod_t mem_q;
   prod_t wb_q;

   logic [1:0][REG_W-1:0] src;
   logic [1:0]            src_use;
   prod_t [2:0]           prod;
   logic [1:0][2:0]       hit;

   logic [1:0] sel_a;
   logic [1:0] sel_b;
   logic       stall_cond;
   logic [0:0] state_q;
   logic [0:0] state_nxt;

   assign ex_prod = '{dest: ex_dest, regwrite: ex_regwrite};
   assign src     = {id_rt, id_rs};
   assign src_use = {id_use_rt, id_use_rs};
   assign prod    = {wb_q, mem_q, ex_prod};

   // hit[s][p]: s = 0 rs / 1 rt, p = 0 EX / 1 MEM / 2 WB
   for (genvar s = 0; s < 2; s++) begin : g_src
      for (genvar p = 0; p < 3; p++) begin : g_prod
         hazard_compare u_cmp (
            .src      (src[s]),
            .src_used (src_use[s]),
            .prod     (prod[p]),
            .hit      (hit[s][p])
         );
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_q <= '0;
         wb_q  <= '0;
      end else begin
         mem_q <= ex_prod;
         wb_q  <= mem_q;
      end
   end

   assign sel_a = fwd_sel(hit[0][0], hit[0][1], hit[0][2], ex_memread);
   assign sel_b = fwd_sel(hit[1][0], hit[1][1], hit[1][2], ex_memread);

`ifdef HFU_FWD_EN
   logic [1:0] fwd_a_q;
   logic [1:0] fwd_b_q;

   assign stall_cond = (hit[0][0] | hit[1][0]) & ex_memread;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fwd_a_q <= FWD_REG;
         fwd_b_q <= FWD_REG;
      end else if (idex_flush) begin
         fwd_a_q <= FWD_REG;
         fwd_b_q <= FWD_REG;
      end else begin
         fwd_a_q <= sel_a;
         fwd_b_q <= sel_b;
      end
   end

   assign ForwardA = fwd_a_q;
   assign ForwardB = fwd_b_q;
`else
   logic [3:0] sel_unused;

   // Without bypass paths every in-flight EX/MEM producer must drain to the regfile.
   assign stall_cond = hit[0][0] | hit[1][0] | hit[0][1] | hit[1][1];
   assign sel_unused = {sel_a, sel_b};
   assign ForwardA   = FWD_REG;
   assign ForwardB   = FWD_REG;
`endif

   always_comb begin
      pc_write   = 1'b1;
      ifid_write = 1'b1;
      ifid_flush = 1'b0;
      idex_flush = 1'b0;
      if (ex_redirect) begin
         ifid_flush = 1'b1;
         idex_flush = 1'b1;
      end else if (stall_cond) begin
         pc_write   = 1'b0;
         ifid_write = 1'b0;
         idex_flush = 1'b1;
      end
   end

   always_comb begin
      state_nxt = state_q;
      case (state_q)
         ST_RUN:   if (stall_cond && !ex_redirect) state_nxt = ST_STALL;
         ST_STALL: if (ex_redirect || !stall_cond) state_nxt = ST_RUN;
         default:  state_nxt = ST_RUN;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_RUN;
      end else begin
         state_q <= state_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt <= '0;
      end else if (!pc_write && (stall_cnt != {STALL_CNT_W{1'b1}})) begin
         stall_cnt <= stall_cnt + STALL_CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_hazard_forward_unit.sv
// Randomized and directed checks of hazard_forward_unit against a pipeline-history reference model.
module tb_hazard_forward_unit;

`ifdef HFU_FWD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n;
   logic [4:0]  id_rs, id_rt, ex_dest;
   logic        id_use_rs, id_use_rt, ex_regwrite, ex_memread, ex_redirect;
   logic [1:0]  ForwardA, ForwardB;
   logic        pc_write, ifid_write, ifid_flush, idex_flush;
   logic [15:0] stall_cnt;

   hazard_forward_unit dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .id_rs       (id_rs),
      .id_rt       (id_rt),
      .id_use_rs   (id_use_rs),
      .id_use_rt   (id_use_rt),
      .ex_dest     (ex_dest),
      .ex_regwrite (ex_regwrite),
      .ex_memread  (ex_memread),
      .ex_redirect (ex_redirect),
      .ForwardA    (ForwardA),
      .ForwardB    (ForwardB),
      .pc_write    (pc_write),
      .ifid_write  (ifid_write),
      .ifid_flush  (ifid_flush),
      .idex_flush  (idex_flush),
      .stall_cnt   (stall_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [4:0] dest;
      bit         wr;
   } prod_t;

   prod_t      hist[$];   // producers that have left EX, newest first
   logic [1:0] m_fa, m_fb;
   int         m_cnt;
   int         n_chk, n_pass;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   function automatic bit reads(input logic [4:0] src, input bit used, input prod_t p);
      return used && p.wr && (p.dest != 5'd0) && (src == p.dest);
   endfunction

   task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input bit urs, input bit urt,
                        input logic [4:0] dst, input bit rw, input bit mr, input bit rd);
      id_rs = rs; id_rt = rt; id_use_rs = urs; id_use_rt = urt;
      ex_dest = dst; ex_regwrite = rw; ex_memread = mr; ex_redirect = rd;
   endtask

   task automatic step(input logic [4:0] rs, input logic [4:0] rt, input bit urs, input bit urt,
                       input logic [4:0] dst, input bit rw, input bit mr, input bit rd,
                       input bit do_chk);
      prod_t      ex, mem;
      bit         ea, eb, ma, mb, stall, exp_pc, exp_flush;
      logic [1:0] na, nb;
      int         exp_cnt;
      @(negedge clk);
      drive(rs, rt, urs, urt, dst, rw, mr, rd);
      #1;
      ex.dest = dst; ex.wr = rw;
      mem.dest = 5'd0; mem.wr = 1'b0;
      if (hist.size() > 0) mem = hist[0];
      ea = reads(rs, urs, ex);  eb = reads(rt, urt, ex);
      ma = reads(rs, urs, mem); mb = reads(rt, urt, mem);
      if (FWD) stall = (ea || eb) && mr;
      else     stall = ea || eb || ma || mb;
      exp_pc    = rd || !stall;
      exp_flush = rd || stall;
      exp_cnt   = (m_cnt > 65535) ? 65535 : m_cnt;
      if (do_chk) begin
         chk("pc_write",   32'(pc_write),   32'(exp_pc));
         chk("ifid_write", 32'(ifid_write), 32'(exp_pc));
         chk("ifid_flush", 32'(ifid_flush), 32'(rd));
         chk("idex_flush", 32'(idex_flush), 32'(exp_flush));
         chk("ForwardA",   32'(ForwardA),   32'(m_fa));
         chk("ForwardB",   32'(ForwardB),   32'(m_fb));
         chk("stall_cnt",  32'(stall_cnt),  32'(exp_cnt));
      end
      if (exp_flush || !FWD) na = 2'b00;
      else if (ea && !mr)    na = 2'b10;
      else if (ma)           na = 2'b01;
      else                   na = 2'b00;
      if (exp_flush || !FWD) nb = 2'b00;
      else if (eb && !mr)    nb = 2'b10;
      else if (mb)           nb = 2'b01;
      else                   nb = 2'b00;
      @(posedge clk);
      if (!exp_pc) m_cnt++;
      m_fa = na; m_fb = nb;
      hist.push_front(ex);
      if (hist.size() > 2) void'(hist.pop_back());
   endtask

   // Asserted and released between clock edges: registered outputs must clear asynchronously.
   task automatic reset_pulse;
      #2 rst_n = 1'b0;
      #1;
      chk("rst_ForwardA",  32'(ForwardA),  32'h0);
      chk("rst_ForwardB",  32'(ForwardB),  32'h0);
      chk("rst_stall_cnt", 32'(stall_cnt), 32'h0);
      drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
      #1;
      chk("rst_pc_write",   32'(pc_write),   32'h1);
      chk("rst_ifid_write", 32'(ifid_write), 32'h1);
      chk("rst_ifid_flush", 32'(ifid_flush), 32'h0);
      chk("rst_idex_flush", 32'(idex_flush), 32'h0);
      hist.delete();
      m_fa = 2'b00; m_fb = 2'b00; m_cnt = 0;
      rst_n = 1'b1;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) step(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
   endtask

   initial begin
      n_chk = 0; n_pass = 0;
      rst_n = 1'b0;
      drive(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
      reset_pulse();

      // forward from EX
      step(5'd3, 5'd0, 1'b1, 1'b0, 5'd3, 1'b1, 1'b0, 1'b0, 1'b1);
      #1 chk("ex_fwd_A", 32'(ForwardA), FWD ? 32'h2 : 32'h0);
      idle(3);

      // EX beats MEM on rt
      step(5'd0, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b1);
      step(5'd0, 5'd5, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b1);
      #1 chk("prio_fwd_B", 32'(ForwardB), FWD ? 32'h2 : 32'h0);
      idle(3);

      // MEM only
      step(5'd0, 5'd0, 1'b0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b1);
      step(5'd0, 5'd5, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
      #1 chk("mem_fwd_B", 32'(ForwardB), FWD ? 32'h1 : 32'h0);
      idle(3);

      // load-use then retried issue behind the bubble
      reset_pulse();
      step(5'd7, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b1);
      #1 chk("lu_cnt", 32'(stall_cnt), 32'h1);
      chk("lu_fwd_A", 32'(ForwardA), 32'h0);
      step(5'd7, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
      #1 chk("lu_retry_A", 32'(ForwardA), FWD ? 32'h1 : 32'h0);
      idle(3);

      // $zero and unused source
      step(5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b1);
      step(5'd0, 5'd4, 1'b0, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0, 1'b1);
      idle(3);

      // redirect overrides load-use
      step(5'd7, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1, 1'b1, 1'b1, 1'b1);
      idle(2);

      // reset mid-stall, inputs still presenting the hazard
      step(5'd7, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b1);
      drive(5'd7, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0);
      reset_pulse();
      idle(2);

      for (int i = 0; i < 1500; i++) begin
         step(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
              ($urandom_range(0, 3) == 0), ($urandom_range(0, 9) == 0), 1'b1);
      end

      // saturation: 65536 stalls reach FFFF, one more must hold it
      reset_pulse();
      for (int i = 0; i < 65536; i++) step(5'd7, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b0);
      step(5'd7, 5'd0, 1'b1, 1'b0, 5'd7, 1'b1, 1'b1, 1'b0, 1'b1);
      #1 chk("sat_cnt", 32'(stall_cnt), 32'hFFFF);
      idle(2);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
